aes_round_key_scheduler: RTL and testbench

Sequencer between the key expansion unit and the iterative AES cipher round datapath. On `start`, it steps through rounds 0..Nr, where Nr = 10, 12 or 14 from the key length. Each round key is presented on a valid/ready handshake together with round-index and first/last-round flags, and completion is signalled with a `done` pulse. Only one cipher operation is in flight at a time. An abort path allows the host to cancel mid-block.

---
 rtl/aes_round_key_scheduler.sv | 130 +++++++++++++
 tb/tb_aes_round_key_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_key_scheduler
//  Function : Steps an iterative AES round datapath through round keys
//             0..Nr over a valid/ready handshake, with abort and done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_key_scheduler #(
    parameter int NR_MAX = 14,
    parameter int RK_W   = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    key_len,
    input  logic                          abort,
    input  logic [0:RK_W*(NR_MAX+1)-1]    exp_key,
    input  logic                          rk_ready,
    output logic                          rk_valid,
    output logic [RK_W-1:0]               round_key,
    output logic [3:0]                    round_idx,
    output logic                          first_round,
    output logic                          last_round,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;
    localparam int         c_slots    = 16;

    logic [1:0]      r_state;
    logic [3:0]      r_nr;
    logic [3:0]      r_round_idx;
    logic [RK_W-1:0] r_round_key;
    logic            r_err;

    logic [RK_W-1:0] w_slice [c_slots];
    logic [3:0]      w_nr_sel;
    logic            w_len_ok;
    logic            w_rk_valid;
    logic            w_hs;
    logic            w_last;
    logic [3:0]      w_next_idx;

    // Slot table indexed by a full 4-bit round number; unused slots read zero.
    generate
        for (genvar g = 0; g < c_slots; g++) begin : g_slice
            if (g <= NR_MAX) begin : g_used
                assign w_slice[g] = exp_key[RK_W*g +: RK_W];
            end else begin : g_pad
                assign w_slice[g] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_nr_sel = 4'd0;
        case (key_len)
            2'd0:    w_nr_sel = 4'd10;
            2'd1:    w_nr_sel = 4'd12;
            2'd2:    w_nr_sel = 4'd14;
            default: w_nr_sel = 4'd0;
        endcase
    end

    // A key length whose schedule does not fit NR_MAX is treated as reserved.
    assign w_len_ok   = (key_len != 2'd3) && (w_nr_sel <= 4'(NR_MAX));
    assign w_rk_valid = (r_state == c_st_issue);
    assign w_hs       = w_rk_valid && rk_ready;
    assign w_last     = (r_round_idx == r_nr);
    assign w_next_idx = r_round_idx + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_nr        <= 4'd0;
            r_round_idx <= 4'd0;
            r_round_key <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_nr        <= w_nr_sel;
                            r_round_idx <= 4'd0;
                            r_round_key <= w_slice[0];
                            r_state     <= c_st_issue;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_st_issue: begin
                    if (abort) begin
                        r_state <= c_st_idle;
                    end else if (w_hs) begin
                        if (w_last) begin
                            r_state <= c_st_done;
                        end else begin
                            r_round_idx <= w_next_idx;
                            r_round_key <= w_slice[w_next_idx];
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rk_valid    = w_rk_valid;
    assign round_key   = r_round_key;
    assign round_idx   = r_round_idx;
    assign first_round = w_rk_valid && (r_round_idx == 4'd0);
    assign last_round  = w_rk_valid && w_last;
    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_round_key_scheduler
//  Function : Directed self-checking bench; expected round keys come from a
//             FIPS-197 key-expansion model anchored by published vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_key_scheduler;

    localparam int NR_MAX = 14;
    localparam int RK_W   = 128;

    localparam logic [2047:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic [1:0]                 key_len = 2'd0;
    logic                       abort = 1'b0;
    logic [0:RK_W*(NR_MAX+1)-1] exp_key = '0;
    logic                       rk_ready = 1'b0;
    logic                       rk_valid;
    logic [RK_W-1:0]            round_key;
    logic [3:0]                 round_idx;
    logic                       first_round;
    logic                       last_round;
    logic                       busy;
    logic                       done;
    logic                       err;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] rk_model [15];

    aes_round_key_scheduler #(.NR_MAX(NR_MAX), .RK_W(RK_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .abort(abort),
        .exp_key(exp_key), .rk_ready(rk_ready), .rk_valid(rk_valid),
        .round_key(round_key), .round_idx(round_idx), .first_round(first_round),
        .last_round(last_round), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [2047:0] t;
        t = C_SBOX;
        return t[(255 - int'(b))*8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int j);
        case (j)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Key expansion model; key is left-aligned in 256 bits.
    task automatic build_model(input logic [1:0] kl, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] tmp;
        int nk;
        int nr;
        nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0)
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(i/nk), 24'h0};
            else if (nk > 6 && i % nk == 4)
                tmp = sub_word(tmp);
            w[i] = w[i-nk] ^ tmp;
        end
        exp_key = '0;
        for (int r = 0; r < 15; r++) begin
            rk_model[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
            exp_key[RK_W*r +: RK_W] = rk_model[r];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 128'(rk_valid), 128'h0);
        check({tag, "_busy"},  128'(busy),     128'h0);
        check({tag, "_done"},  128'(done),     128'h0);
        check({tag, "_err"},   128'(err),      128'h0);
        check({tag, "_first"}, 128'(first_round), 128'h0);
        check({tag, "_last"},  128'(last_round),  128'h0);
        check({tag, "_idx"},   128'(round_idx),   128'h0);
        check({tag, "_key"},   round_key,         128'h0);
    endtask

    // One operation; start_at/abort_at/reset_at are round numbers (-1 = unused).
    task automatic run_op(input logic [1:0] kl, input int nr, input bit rand_ready,
                          input int start_at, input int abort_at, input int reset_at);
        int  exp_idx;
        int  cyc;
        bit  fin;
        exp_idx = 0;
        cyc     = 0;
        fin     = 1'b0;
        key_len = kl;
        start   = 1'b1;
        tick();
        cyc++;
        start   = 1'b0;
        key_len = (kl == 2'd0) ? 2'd2 : 2'd0;
        while (!fin && cyc < 400) begin
            if (exp_idx <= nr) begin
                check("valid", 128'(rk_valid), 128'h1);
                check("idx",   128'(round_idx), 128'(exp_idx));
                check("key",   round_key, rk_model[exp_idx]);
                check("first", 128'(first_round), 128'(exp_idx == 0));
                check("last",  128'(last_round),  128'(exp_idx == nr));
                check("busy",  128'(busy), 128'h1);
                check("done_early", 128'(done), 128'h0);
                if (exp_idx == reset_at) begin
                    #2 rst_n = 1'b0;
                    #1 check_all_zero("async_rst");
                    tick();
                    check_all_zero("rst_held");
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                if (exp_idx == abort_at) begin
                    abort    = 1'b1;
                    rk_ready = 1'b1;
                    tick();
                    abort    = 1'b0;
                    rk_ready = 1'b0;
                    check("abort_valid", 128'(rk_valid), 128'h0);
                    check("abort_busy",  128'(busy), 128'h0);
                    check("abort_done",  128'(done), 128'h0);
                    tick();
                    check("abort_nodone", 128'(done), 128'h0);
                    return;
                end
                start    = (exp_idx == start_at);
                rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
                cyc++;
                start = 1'b0;
                if (rk_ready) exp_idx++;
            end else begin
                check("done",       128'(done), 128'h1);
                check("done_valid", 128'(rk_valid), 128'h0);
                check("done_last",  128'(last_round), 128'h0);
                check("done_busy",  128'(busy), 128'h1);
                if (!rand_ready) check("done_lat", 128'(cyc), 128'(nr + 2));
                rk_ready = 1'b0;
                tick();
                check("post_done", 128'(done), 128'h0);
                check("post_busy", 128'(busy), 128'h0);
                fin = 1'b1;
            end
        end
        check("timeout", 128'(fin), 128'h1);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        build_model(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        check("aes128_r0",  rk_model[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("aes128_r10", rk_model[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_op(2'd0, 10, 1'b0, -1, -1, -1);

        build_model(2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        check("aes192_r12", rk_model[12], 128'he98ba06f448c773c8ecc720401002202);
        run_op(2'd1, 12, 1'b0, -1, -1, -1);
        run_op(2'd1, 12, 1'b1, -1, -1, -1);

        build_model(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        check("aes256_r14", rk_model[14], 128'hfe4890d1e6188d0b046df344706c631e);
        run_op(2'd2, 14, 1'b0, 4, -1, -1);
        run_op(2'd2, 14, 1'b1, -1, -1, -1);

        key_len = 2'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("err_pulse", 128'(err), 128'h1);
        check("err_busy",  128'(busy), 128'h0);
        check("err_valid", 128'(rk_valid), 128'h0);
        tick();
        check("err_clear", 128'(err), 128'h0);
        check("err_idle",  128'(busy), 128'h0);

        build_model(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        run_op(2'd0, 10, 1'b0, -1, 5, -1);
        run_op(2'd0, 10, 1'b0, -1, -1, -1);
        run_op(2'd0, 10, 1'b1, -1, -1, 7);
        run_op(2'd0, 10, 1'b0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
